// File: rtl/input_skew_2x2.sv
// Two-lane input skew stage for the 2x2 systolic array: lane 1 lags lane 0 by one beat, and each tile ends with a drain beat.
// Optional INPUT_SKEW_STATS_EN adds a tile_count port that counts accepted m_last beats.
module input_skew_2x2 #(
    parameter int WIDTH = 16,
    parameter int ROWS  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mux_reset,
    input  logic [2*WIDTH-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [2*WIDTH-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
`ifdef INPUT_SKEW_STATS_EN
    output logic [15:0]        tile_count,
`endif
    output logic               busy
);

    localparam int CW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_rowCount;
    logic [CW-1:0]    w_nextCount;
    logic [WIDTH-1:0] r_skew;
    logic [WIDTH-1:0] r_out0;
    logic [WIDTH-1:0] r_out1;
    logic             r_valid;
    logic             r_last;

    logic             w_adv;
    logic             w_accept;
    logic             w_drainLoad;
    logic             w_load;
    logic [WIDTH-1:0] w_next0;
    logic [WIDTH-1:0] w_next1;
    logic [WIDTH-1:0] w_nextSkew;

    // A full output register with no downstream acceptance stalls the whole stage.
    assign w_adv       = !r_valid || m_ready;
    assign s_ready     = w_adv && (r_state != DRAIN) && !rst;
    assign w_accept    = s_valid && s_ready;
    assign w_drainLoad = w_adv && (r_state == DRAIN);
    assign w_load      = w_accept || w_drainLoad;

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_rowCount;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = STREAM;
                    w_nextCount = CW'(1);
                end
            end
            STREAM: begin
                if (w_accept) begin
                    w_nextCount = r_rowCount + CW'(1);
                    if (r_rowCount == CW'(ROWS - 1)) begin
                        w_nextState = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_drainLoad) begin
                    w_nextState = IDLE;
                    w_nextCount = '0;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCount = '0;
            end
        endcase
    end

    // The drain beat carries the last held lane-1 element, and the skew register is emptied for the next tile.
    always_comb begin
        w_next0    = w_accept ? s_data[WIDTH-1:0] : '0;
        w_next1    = r_skew;
        w_nextSkew = r_skew;
        if (w_drainLoad) begin
            w_nextSkew = '0;
        end else if (w_accept) begin
            w_nextSkew = s_data[2*WIDTH-1:WIDTH];
        end
        if (mux_reset[1]) begin
            w_next0 = '0;
        end
        if (mux_reset[0]) begin
            w_next1 = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rowCount <= '0;
            r_skew     <= '0;
            r_out0     <= '0;
            r_out1     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_rowCount <= w_nextCount;
            r_skew     <= w_nextSkew;
            if (w_load) begin
                r_out0  <= w_next0;
                r_out1  <= w_next1;
                r_valid <= 1'b1;
                r_last  <= w_drainLoad;
            end else if (m_ready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

`ifdef INPUT_SKEW_STATS_EN
    logic [15:0] r_tileCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tileCount <= '0;
        end else if (r_valid && r_last && m_ready) begin
            r_tileCount <= r_tileCount + 16'd1;
        end
    end

    assign tile_count = r_tileCount;
`endif

    assign m_data  = {r_out1, r_out0};
    assign m_valid = r_valid;
    assign m_last  = r_last;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_input_skew_2x2.sv
// Directed bench for input_skew_2x2: each scenario task drives a tile and compares captured beats against an expected-beat model.
// Define INPUT_SKEW_STATS_EN to also exercise the tile_count port.
module tb_input_skew_2x2;

    localparam int WIDTH = 16;
    localparam int ROWS  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         mux_reset;
    logic [2*WIDTH-1:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic [2*WIDTH-1:0] m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;
    logic               busy;
`ifdef INPUT_SKEW_STATS_EN
    logic [15:0]        tile_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [2*WIDTH-1:0] capData[$];
    logic               capLast[$];

    input_skew_2x2 #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst       (rst),
        .mux_reset (mux_reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
`ifdef INPUT_SKEW_STATS_EN
        .tile_count(tile_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Record every output handshake just before the edge that completes it.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            capData.push_back(m_data);
            capLast.push_back(m_last);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected beat i of a tile whose lanes carry b0+k and b1+k: {last, lane1, lane0}.
    function automatic logic [2*WIDTH:0] expBeat(input int i, input int b0, input int b1, input logic [1:0] mr);
        logic [WIDTH-1:0] l0;
        logic [WIDTH-1:0] l1;
        l0 = (i < ROWS && !mr[1]) ? WIDTH'(b0 + i) : '0;
        l1 = (i > 0 && !mr[0]) ? WIDTH'(b1 + i - 1) : '0;
        return {(i == ROWS), l1, l0};
    endfunction

    function automatic logic [2*WIDTH:0] gotBeat(input int i);
        if (i < capData.size()) begin
            return {capLast[i], capData[i]};
        end
        return 'x;
    endfunction

    task automatic sendBeat(input int l0, input int l1);
        int n = 0;
        s_valid = 1'b1;
        s_data  = {WIDTH'(l1), WIDTH'(l0)};
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 60) begin
                total++;
                bad++;
                $display("[TB] FAIL acceptTimeout: got s_ready=0 expected s_ready=1 within 60 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic sendTile(input int b0, input int b1, input bit gaps);
        for (int i = 0; i < ROWS; i++) begin
            sendBeat(b0 + i, b1 + i);
            if (gaps && i < ROWS - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic waitBeats(input int n);
        int c = 0;
        while (capData.size() < n && c < 100) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] mr);
        mux_reset = mr;
        capData.delete();
        capLast.delete();
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        s_valid   = 1'b1;
        s_data    = '0;
        m_ready   = 1'b1;
        mux_reset = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL resetSready: got %b expected 0", s_ready); end
        total++; if (m_data !== '0) begin bad++; $display("[TB] FAIL resetData: got %h expected 0", m_data); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL resetValid: got %b expected 0", m_valid); end
        total++; if (m_last !== 1'b0) begin bad++; $display("[TB] FAIL resetLast: got %b expected 0", m_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL resetBusy: got %b expected 0", busy); end
`ifdef INPUT_SKEW_STATS_EN
        total++; if (tile_count !== 16'd0) begin bad++; $display("[TB] FAIL resetTileCount: got %0d expected 0", tile_count); end
`endif
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        applyStimulus(2'b00);
        sendTile(1, 11, 1'b0);
        waitBeats(ROWS + 1);
        total++; if (capData.size() != ROWS + 1) begin bad++; $display("[TB] FAIL basicCount: got %0d expected %0d", capData.size(), ROWS + 1); end
        for (int i = 0; i <= ROWS; i++) begin
            total++;
            if (gotBeat(i) !== expBeat(i, 1, 11, 2'b00)) begin
                bad++;
                $display("[TB] FAIL basicBeat%0d: got %h expected %h", i, gotBeat(i), expBeat(i, 1, 11, 2'b00));
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basicIdle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_backpressure;
        bit stall1 = 1'b0;
        bit stall3 = 1'b0;
        logic [2*WIDTH-1:0] held;
        applyStimulus(2'b00);
        fork
            sendTile(1, 11, 1'b0);
            begin
                for (int c = 0; c < 30; c++) begin
                    @(posedge clk);
                    #1;
                    if (m_valid && ((capData.size() == 1 && !stall1) || (capData.size() == 3 && !stall3))) begin
                        if (capData.size() == 1) stall1 = 1'b1; else stall3 = 1'b1;
                        m_ready = 1'b0;
                        held    = m_data;
                        @(negedge clk);
                        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL stallSready: got %b expected 0", s_ready); end
                        @(posedge clk);
                        #1;
                        total++; if (m_data !== held || m_valid !== 1'b1) begin bad++; $display("[TB] FAIL stallHold: got %h/%b expected %h/1", m_data, m_valid, held); end
                        m_ready = 1'b1;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            end
        join
        waitBeats(ROWS + 1);
        total++; if (!(stall1 && stall3)) begin bad++; $display("[TB] FAIL stallsApplied: got %b%b expected 11", stall1, stall3); end
        total++; if (capData.size() != ROWS + 1) begin bad++; $display("[TB] FAIL bpCount: got %0d expected %0d", capData.size(), ROWS + 1); end
        for (int i = 0; i <= ROWS; i++) begin
            total++;
            if (gotBeat(i) !== expBeat(i, 1, 11, 2'b00)) begin
                bad++;
                $display("[TB] FAIL bpBeat%0d: got %h expected %h", i, gotBeat(i), expBeat(i, 1, 11, 2'b00));
            end
        end
    endtask

    task automatic test_gaps;
        applyStimulus(2'b00);
        sendTile(1, 11, 1'b1);
        waitBeats(ROWS + 1);
        total++; if (capData.size() != ROWS + 1) begin bad++; $display("[TB] FAIL gapCount: got %0d expected %0d", capData.size(), ROWS + 1); end
        for (int i = 0; i <= ROWS; i++) begin
            total++;
            if (gotBeat(i) !== expBeat(i, 1, 11, 2'b00)) begin
                bad++;
                $display("[TB] FAIL gapBeat%0d: got %h expected %h", i, gotBeat(i), expBeat(i, 1, 11, 2'b00));
            end
        end
    endtask

    task automatic test_back_to_back;
        bit window = 1'b1;
        int lowCount = 0;
        applyStimulus(2'b00);
        fork
            begin
                sendTile(1, 11, 1'b0);
                sendTile(21, 31, 1'b0);
                window = 1'b0;
            end
            begin
                while (window) begin
                    @(negedge clk);
                    if (window && !s_ready) lowCount++;
                end
            end
        join
        waitBeats(2 * (ROWS + 1));
        total++; if (lowCount != 1) begin bad++; $display("[TB] FAIL b2bReadyLow: got %0d expected 1", lowCount); end
        total++; if (capData.size() != 2 * (ROWS + 1)) begin bad++; $display("[TB] FAIL b2bCount: got %0d expected %0d", capData.size(), 2 * (ROWS + 1)); end
        for (int i = 0; i <= ROWS; i++) begin
            total++;
            if (gotBeat(i) !== expBeat(i, 1, 11, 2'b00)) begin
                bad++;
                $display("[TB] FAIL b2bTileA%0d: got %h expected %h", i, gotBeat(i), expBeat(i, 1, 11, 2'b00));
            end
            total++;
            if (gotBeat(i + ROWS + 1) !== expBeat(i, 21, 31, 2'b00)) begin
                bad++;
                $display("[TB] FAIL b2bTileB%0d: got %h expected %h", i, gotBeat(i + ROWS + 1), expBeat(i, 21, 31, 2'b00));
            end
        end
    endtask

    task automatic test_lane_zero;
        applyStimulus(2'b10);
        sendTile(1, 11, 1'b0);
        waitBeats(ROWS + 1);
        for (int i = 0; i <= ROWS; i++) begin
            total++;
            if (gotBeat(i) !== expBeat(i, 1, 11, 2'b10)) begin
                bad++;
                $display("[TB] FAIL zero10Beat%0d: got %h expected %h", i, gotBeat(i), expBeat(i, 1, 11, 2'b10));
            end
        end
        applyStimulus(2'b01);
        sendTile(5, 15, 1'b0);
        waitBeats(ROWS + 1);
        for (int i = 0; i <= ROWS; i++) begin
            total++;
            if (gotBeat(i) !== expBeat(i, 5, 15, 2'b01)) begin
                bad++;
                $display("[TB] FAIL zero01Beat%0d: got %h expected %h", i, gotBeat(i), expBeat(i, 5, 15, 2'b01));
            end
        end
        mux_reset = 2'b00;
    endtask

    task automatic test_mid_reset;
        applyStimulus(2'b00);
        sendBeat(1, 11);
        sendBeat(2, 12);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        capData.delete();
        capLast.delete();
        @(negedge clk);
        total++; if (m_data !== '0) begin bad++; $display("[TB] FAIL midRstData: got %h expected 0", m_data); end
        total++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin bad++; $display("[TB] FAIL midRstValid: got %b%b expected 00", m_valid, m_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midRstBusy: got %b expected 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (capData.size() != 0) begin bad++; $display("[TB] FAIL midRstNoDrain: got %0d beats expected 0", capData.size()); end
        sendTile(41, 51, 1'b0);
        waitBeats(ROWS + 1);
        for (int i = 0; i <= ROWS; i++) begin
            total++;
            if (gotBeat(i) !== expBeat(i, 41, 51, 2'b00)) begin
                bad++;
                $display("[TB] FAIL midRstBeat%0d: got %h expected %h", i, gotBeat(i), expBeat(i, 41, 51, 2'b00));
            end
        end
    endtask

`ifdef INPUT_SKEW_STATS_EN
    task automatic test_stats;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(2'b00);
        for (int t = 0; t < 3; t++) begin
            sendTile(t * 4, 100 + t * 4, 1'b0);
        end
        waitBeats(3 * (ROWS + 1));
        total++; if (tile_count !== 16'd3) begin bad++; $display("[TB] FAIL statsThree: got %0d expected 3", tile_count); end
        force dut.r_tileCount = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.r_tileCount;
        applyStimulus(2'b00);
        sendTile(7, 17, 1'b0);
        waitBeats(ROWS + 1);
        total++; if (tile_count !== 16'd0) begin bad++; $display("[TB] FAIL statsWrap: got %h expected 0000", tile_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_back_to_back();
        test_lane_zero();
        test_mid_reset();
`ifdef INPUT_SKEW_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
